imem_uart_loader: RTL and testbench

//  Writer side of the instruction memory. Takes a byte stream from the UART receiver, frames it into
//  32-bit words and writes them into the imem write port. Holds the CPU in reset while a load runs.

---
 rtl/imem_uart_loader_if.sv | 22 ++
 rtl/imem_uart_loader.sv | 165 ++++++++++++++++
 tb/tb_imem_uart_loader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_uart_loader_if.sv
// Bundle between uart_rx, the imem write port and the CPU reset control.
// master = loader side, slave = surrounding system / testbench.
interface imem_uart_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  modport master (
    input  rx_valid, rx_byte,
    output imem_we, imem_waddr, imem_wdata, cpu_hold, load_done, load_err
  );

  modport slave (
    output rx_valid, rx_byte,
    input  imem_we, imem_waddr, imem_wdata, cpu_hold, load_done, load_err
  );
endinterface

// File: rtl/imem_uart_loader.sv
// Frames a UART byte stream (SYNC, COUNT, N*4 data bytes) into 32-bit imem writes, holding the CPU in reset.
// Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
module imem_uart_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               reset,
  imem_uart_loader_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_FINISH
  } state_t;

  state_t          state, nxt;
  logic [7:0]      cnt_n;
  logic [7:0]      word_idx;
  logic [1:0]      byte_idx;
  logic [23:0]     shreg;
  logic [TW-1:0]   tmo;
  logic            we_q, hold_q, err_q;
  logic [7:0]      waddr_q;
  logic [31:0]     wdata_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  logic counting, wr, sync, abort, tmo_hit, last_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  // An rx_valid always wins over the timeout limit in the same cycle.
  always_comb begin
    nxt       = state;
    wr        = 1'b0;
    sync      = 1'b0;
    abort     = 1'b0;
    counting  = 1'b0;
    tmo_hit   = (tmo == TW'(TIMEOUT_CYCLES - 1));
    last_word = (word_idx == cnt_n - 8'd1);
    case (state)
      S_IDLE: begin
        if (bus.rx_valid && bus.rx_byte == SYNC_BYTE) begin
          sync = 1'b1;
          nxt  = S_COUNT;
        end
      end
      S_COUNT: begin
        counting = 1'b1;
        if (bus.rx_valid) nxt = S_DATA;
        else if (tmo_hit) begin
          abort = 1'b1;
          nxt   = S_IDLE;
        end
      end
      S_DATA: begin
        counting = 1'b1;
        if (bus.rx_valid) begin
          if (byte_idx == 2'd3) begin
            wr = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            if (last_word) nxt = S_CSUM;
`else
            if (last_word) nxt = S_FINISH;
`endif
          end
        end else if (tmo_hit) begin
          abort = 1'b1;
          nxt   = S_IDLE;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        counting = 1'b1;
        if (bus.rx_valid) begin
          if (bus.rx_byte == csum) nxt = S_FINISH;
          else begin
            abort = 1'b1;
            nxt   = S_IDLE;
          end
        end else if (tmo_hit) begin
          abort = 1'b1;
          nxt   = S_IDLE;
        end
      end
`endif
      S_FINISH: nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_n    <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      tmo      <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      hold_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      we_q <= wr;
      if (wr) begin
        waddr_q <= word_idx;
        wdata_q <= {shreg, bus.rx_byte};
      end
      tmo <= (counting && !bus.rx_valid && !abort) ? tmo + 1'b1 : '0;

      if (sync) begin
        hold_q <= 1'b1;
        err_q  <= 1'b0;
      end else if (abort) begin
        hold_q <= 1'b0;
        err_q  <= 1'b1;
      end else if (state == S_FINISH) begin
        hold_q <= 1'b0;
      end

      if (state == S_COUNT && bus.rx_valid) begin
        cnt_n    <= bus.rx_byte;
        word_idx <= '0;
        byte_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum     <= '0;
`endif
      end

      // Only the three older bytes are kept; the fourth goes straight into wdata.
      if (state == S_DATA && bus.rx_valid) begin
        shreg    <= {shreg[15:0], bus.rx_byte};
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) word_idx <= word_idx + 8'd1;
`ifdef LOADER_CHECKSUM_EN
        csum     <= csum ^ bus.rx_byte;
`endif
      end
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.cpu_hold   = hold_q;
  assign bus.load_done  = (state == S_FINISH);
  assign bus.load_err   = err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: directed frame table, reset/timeout/checksum corners, random frame streams vs a parser model.
module tb_imem_uart_loader;
  localparam int         TMO  = 40;
  localparam logic [7:0] SYNC = 8'hA5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  imem_uart_loader_if bus();
  imem_uart_loader #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] a; logic [31:0] d; int c; } wr_t;
  typedef struct { logic [7:0] b0, b1, b2, b3; logic [31:0] wd; logic [7:0] cs; } vec_t;

  wr_t        wq[$], eq[$];
  logic [7:0] sq[$];
  int         gq[$], bq[$];
  int         done_cnt = 0, both_bad = 0, tests = 0, fails = 0, last_cyc = 0, exp_done = 0;
  logic       exp_err = 1'b0;

  always @(negedge clk) begin
    if (bus.imem_we) wq.push_back(wr_t'{bus.imem_waddr, bus.imem_wdata, cyc});
    if (bus.load_done) done_cnt++;
    if (bus.load_done && bus.load_err) both_bad++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.imem_we, bus.imem_waddr, bus.imem_wdata, bus.cpu_hold, bus.load_done, bus.load_err});
  endfunction

  // Called at a negedge; rx_valid is high across exactly one rising edge.
  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic rst_pulse();
    bus.rx_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] b, input int g);
    sq.push_back(b);
    gq.push_back(g);
  endtask

  function automatic logic [7:0] junk();
    logic [7:0] j;
    j = 8'($urandom);
    return (j == SYNC) ? 8'h5A : j;
  endfunction

  task automatic build_frame(input int n, input bit bad);
    logic [7:0] x, b, cs;
    int nw;
    x  = 8'h00;
    nw = (n == 0) ? 256 : n;
    push_b(SYNC, $urandom_range(0, 2));
    push_b(8'(n), $urandom_range(0, 2));
    for (int k = 0; k < nw * 4; k++) begin
      b = 8'($urandom);
      x ^= b;
      push_b(b, (nw == 256) ? 0 : $urandom_range(0, 2));
    end
    cs = bad ? ~x : x;
`ifndef LOADER_CHECKSUM_EN
    if (cs == SYNC) cs = 8'h00;
`endif
    push_b(cs, $urandom_range(0, 2));
  endtask

  // Walks the byte list as frames; a byte arriving the cycle right after a completed frame is dropped.
  task automatic model();
    int i, fin, nw;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x;
`endif
    i = 0; fin = -2;
    eq.delete();
    exp_done = 0;
    while (i < sq.size()) begin
      if (i == fin + 1 && gq[i] == 0) begin i++; continue; end
      if (sq[i] != SYNC) begin i++; continue; end
      exp_err = 1'b0;
      nw = (sq[i+1] == 8'h00) ? 256 : int'(sq[i+1]);
      i += 2;
`ifdef LOADER_CHECKSUM_EN
      x = 8'h00;
`endif
      for (int w = 0; w < nw; w++) begin
        eq.push_back(wr_t'{8'(w), {sq[i], sq[i+1], sq[i+2], sq[i+3]}, bq[i+3]});
`ifdef LOADER_CHECKSUM_EN
        x ^= sq[i] ^ sq[i+1] ^ sq[i+2] ^ sq[i+3];
`endif
        i += 4;
      end
`ifdef LOADER_CHECKSUM_EN
      if (sq[i] == x) begin exp_done++; fin = i; end
      else exp_err = 1'b1;
      i++;
`else
      exp_done++;
      fin = i - 1;
`endif
    end
  endtask

  task automatic run_stream();
    int d0, b0, n;
    wq.delete(); bq.delete();
    d0 = done_cnt; b0 = both_bad;
    for (int i = 0; i < sq.size(); i++) begin
      send(sq[i], gq[i]);
      bq.push_back(last_cyc);
    end
    repeat (5) @(negedge clk);
    model();
    chk("stream_nwrites", 64'(wq.size()), 64'(eq.size()));
    n = (wq.size() < eq.size()) ? wq.size() : eq.size();
    for (int i = 0; i < n; i++) begin
      chk("stream_waddr", 64'(wq[i].a), 64'(eq[i].a));
      chk("stream_wdata", 64'(wq[i].d), 64'(eq[i].d));
      chk("stream_wcycle", 64'(wq[i].c), 64'(eq[i].c));
    end
    chk("stream_done", 64'(done_cnt - d0), 64'(exp_done));
    chk("stream_err", 64'(bus.load_err), 64'(exp_err));
    chk("stream_hold", 64'(bus.cpu_hold), 64'd0);
    chk("stream_done_err_overlap", 64'(both_bad - b0), 64'd0);
  endtask

  initial begin
    vec_t vt[5];
    int d0, c, e;
    vt[0] = '{8'h20, 8'h01, 8'h00, 8'h01, 32'h20010001, 8'h20};
    vt[1] = '{8'hA5, 8'h00, 8'hFF, 8'h13, 32'hA500FF13, 8'h49};
    vt[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF, 8'h00};
    vt[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000, 8'h00};
    vt[4] = '{8'h12, 8'h34, 8'h56, 8'h78, 32'h12345678, 8'h08};

    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    #1 chk("reset_outputs", outs(), 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_outputs", outs(), 64'd0);

    // Single-word frames preceded by junk; the A5 inside the data is plain data.
    for (int v = 0; v < 5; v++) begin
      wq.delete();
      d0 = done_cnt;
      send(8'h00, 1); send(8'hFF, 0); send(8'h13, 0); send(SYNC, 0);
      chk("hold_in_frame", 64'(bus.cpu_hold), 64'd1);
      send(8'h01, 0);
      send(vt[v].b0, 0); send(vt[v].b1, 1); send(vt[v].b2, 0); send(vt[v].b3, 2);
      c = last_cyc;
`ifdef LOADER_CHECKSUM_EN
      send(vt[v].cs, 0);
`endif
      repeat (3) @(negedge clk);
      chk("vec_nwrites", 64'(wq.size()), 64'd1);
      if (wq.size() > 0) begin
        chk("vec_waddr", 64'(wq[0].a), 64'd0);
        chk("vec_wdata", 64'(wq[0].d), 64'(vt[v].wd));
        chk("vec_wlatency", 64'(wq[0].c), 64'(c));
      end
      chk("vec_done", 64'(done_cnt - d0), 64'd1);
      chk("vec_err", 64'(bus.load_err), 64'd0);
      chk("vec_hold", 64'(bus.cpu_hold), 64'd0);
    end

    // Reset in the middle of DATA, in the very cycle imem_we is high.
    send(SYNC, 1); send(8'h02, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    chk("we_before_reset", 64'(bus.imem_we), 64'd1);
    #2 reset = 1'b1;
    #1 chk("reset_mid_data", outs(), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    wq.delete();
    send(8'h55, 0); send(8'h66, 0); send(8'h77, 0); send(8'h88, 0);
    repeat (3) @(negedge clk);
    chk("no_we_after_reset", 64'(wq.size()), 64'd0);
    chk("hold_after_reset", 64'(bus.cpu_hold), 64'd0);

    // Timeout after the 5th data byte of a two-word frame.
    wq.delete();
    send(SYNC, 1); send(8'h02, 0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0); send(8'h05, 0);
    c = last_cyc;
    e = -1;
    for (int k = 0; k < TMO + 10; k++) begin
      @(negedge clk);
      if (bus.load_err) begin e = cyc; break; end
    end
    chk("timeout_latency", 64'(e - c), 64'(TMO));
    chk("timeout_nwrites", 64'(wq.size()), 64'd1);
    if (wq.size() > 0) chk("timeout_wdata", 64'(wq[0].d), 64'h01020304);
    chk("timeout_hold", 64'(bus.cpu_hold), 64'd0);
    send(SYNC, 1);
    chk("err_cleared_by_sync", 64'(bus.load_err), 64'd0);
    chk("hold_after_resync", 64'(bus.cpu_hold), 64'd1);
    rst_pulse();

`ifdef LOADER_CHECKSUM_EN
    wq.delete();
    d0 = done_cnt;
    send(SYNC, 1); send(8'h01, 0);
    send(8'h20, 0); send(8'h01, 0); send(8'h00, 0); send(8'h01, 0); send(8'h21, 0);
    repeat (3) @(negedge clk);
    chk("badcsum_err", 64'(bus.load_err), 64'd1);
    chk("badcsum_done", 64'(done_cnt - d0), 64'd0);
    chk("badcsum_nwrites", 64'(wq.size()), 64'd1);
    if (wq.size() > 0) chk("badcsum_waddr", 64'(wq[0].a), 64'd0);
    chk("badcsum_hold", 64'(bus.cpu_hold), 64'd0);
    rst_pulse();
`endif

    for (int s = 0; s < 8; s++) begin
      rst_pulse();
      exp_err = 1'b0;
      sq.delete(); gq.delete();
      repeat ($urandom_range(1, 3)) push_b(junk(), $urandom_range(0, 2));
      repeat ($urandom_range(1, 3)) begin
        build_frame($urandom_range(1, 4), ($urandom % 4) == 0);
        repeat ($urandom_range(1, 2)) push_b(junk(), $urandom_range(0, 2));
      end
      run_stream();
    end

    // N=0: full 256-word load.
    rst_pulse();
    exp_err = 1'b0;
    sq.delete(); gq.delete();
    push_b(junk(), 1);
    build_frame(0, 1'b0);
    push_b(junk(), 1);
    run_stream();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
